// File: rtl/dl_port_sequencer.sv
// Shares the ROM/work memory port between the hps_io download stream and the core fetch port.
// Optional download checksum output dl_sum is built only when DL_PORT_CHECKSUM_EN is defined.
module dl_port_sequencer #(
    parameter int          ADDR_W      = 16,
    parameter int unsigned ROM_SIZE    = 32'h0000_A000,
    parameter int          HOLD_CYCLES = 1024
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              mem_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              core_reset,
    output logic              core_grant,
    output logic              dl_done,
    output logic              addr_err
`ifdef DL_PORT_CHECKSUM_EN
    ,
    output logic [7:0]        dl_sum
`endif
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam int                CNT_W     = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W:0]   ROM_LIMIT = (ADDR_W + 1)'(ROM_SIZE);

    logic [1:0]        state;
    logic              dl_q;
    logic              hold_valid;
    logic [ADDR_W-1:0] hold_addr;
    logic [7:0]        hold_data;
    logic [CNT_W-1:0]  hold_cnt;

    logic dl_rise;
    logic loader_owns;
    logic drain;
    logic in_range;
    logic accept;

    assign dl_rise     = ioctl_download & ~dl_q;
    assign loader_owns = (state == LOAD) || (state == DRAIN);
    assign drain       = loader_owns & hold_valid & ~mem_busy;
    assign in_range    = {1'b0, ioctl_addr} < ROM_LIMIT;
    assign accept      = (state == LOAD) & ioctl_wr;

    // The port mux selects on registered state only, keeping ioctl_* off the mem_addr path.
    assign mem_addr   = (state == RUN) ? core_addr : hold_addr;
    assign mem_din    = hold_data;
    assign mem_we     = drain;
    assign ioctl_wait = hold_valid & mem_busy;
    assign core_grant = (state == RUN);
    assign core_reset = (state != RUN);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            dl_q     <= 1'b0;
            hold_cnt <= '0;
            dl_done  <= 1'b0;
        end else begin
            dl_q    <= ioctl_download;
            dl_done <= 1'b0;
            case (state)
                RUN: begin
                    if (dl_rise) state <= LOAD;
                end
                LOAD: begin
                    if (!ioctl_download) state <= DRAIN;
                end
                // Leave DRAIN once the holding register is empty or emptying this cycle.
                DRAIN: begin
                    if (dl_rise) begin
                        state <= LOAD;
                    end else if (!hold_valid || drain) begin
                        state    <= HOLD;
                        hold_cnt <= CNT_LOAD;
                    end
                end
                HOLD: begin
                    if (dl_rise) begin
                        state <= LOAD;
                    end else if (hold_cnt == '0) begin
                        state   <= RUN;
                        dl_done <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // A write arriving on the same cycle the entry drains simply reloads the register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= '0;
        end else begin
            if (accept && in_range && (!hold_valid || drain)) begin
                hold_valid <= 1'b1;
                hold_addr  <= ioctl_addr;
                hold_data  <= ioctl_dout;
            end else if (drain) begin
                hold_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            addr_err <= 1'b0;
        end else if (dl_rise) begin
            addr_err <= 1'b0;
        end else if (accept && (!in_range || (hold_valid && !drain))) begin
            addr_err <= 1'b1;
        end
    end

`ifdef DL_PORT_CHECKSUM_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_sum <= 8'h00;
        end else if (dl_rise) begin
            dl_sum <= 8'h00;
        end else if (mem_we) begin
            dl_sum <= dl_sum + hold_data;
        end
    end
`endif

endmodule
